// File: rtl/cpu_clock_stepper_pkg.sv
// Shared encodings and 50 MHz defaults for the CPU clock stepper.
// The debounce state encoding is exported on db_state for board LEDs.
package cpu_clock_stepper_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } db_state_t;

    typedef enum logic [1:0] {
        GEN_IDLE = 2'd0,
        GEN_HIGH = 2'd1,
        GEN_LOW  = 2'd2,
        GEN_RUN  = 2'd3
    } gen_state_t;

    localparam int unsigned DEF_DB_CYCLES  = 500000;
    localparam int unsigned DEF_RUN_HALF   = 25000000;
    localparam int unsigned DEF_PULSE_HALF = 1000;

    // Width of a counter that runs 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_clock_stepper_if.sv
// Board-side signal bundle of the stepper: raw key/switch in, CPU clock and debug out.
// master is the stepper itself; slave is whatever drives the pins and watches the clock.
interface cpu_clock_stepper_if;

    logic       key_n;
    logic       mode_run;
    logic       cpu_clk;
    logic       cpu_clk_rise;
    logic [7:0] step_count;
    logic       key_db;
    logic [1:0] db_state;

    modport master (
        input  key_n, mode_run,
        output cpu_clk, cpu_clk_rise, step_count, key_db, db_state
    );

    modport slave (
        output key_n, mode_run,
        input  cpu_clk, cpu_clk_rise, step_count, key_db, db_state
    );

endinterface

// File: rtl/cpu_clock_stepper_key_debounce.sv
// Two-flop synchronizer plus press/release debounce FSM for one active-low key.
// step_req pulses for one cycle on each accepted press.
module key_debounce
    import cpu_clock_stepper_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      key_n,
    output logic      key_db,
    output logic      step_req,
    output db_state_t db_state
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          key_meta;
    logic          key_sync;
    logic [CW-1:0] cnt;
    logic          settled;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    assign settled = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_state <= IDLE;
            cnt      <= '0;
            key_db   <= 1'b0;
        end else begin
            case (db_state)
                IDLE: begin
                    if (!key_sync) begin
                        db_state <= PRESS_DB;
                        cnt      <= '0;
                    end
                end
                PRESS_DB: begin
                    if (key_sync) begin
                        db_state <= IDLE;
                    end else if (settled) begin
                        db_state <= HELD;
                        key_db   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_sync) begin
                        db_state <= REL_DB;
                        cnt      <= '0;
                    end
                end
                REL_DB: begin
                    // A release bounce drops back to HELD, which never re-issues step_req.
                    if (!key_sync) begin
                        db_state <= HELD;
                    end else if (settled) begin
                        db_state <= IDLE;
                        key_db   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: db_state <= IDLE;
            endcase
        end
    end

    // Decoded from the PRESS_DB -> HELD transition so it lines up with that edge.
    assign step_req = (db_state == PRESS_DB) && !key_sync && settled;

endmodule

// File: rtl/cpu_clock_stepper.sv
// CPU clock source: free-running divided clock in run mode, one debounced pulse per key in step mode.
// Mode changes take effect only while cpu_clk is low and no pulse is in flight.
module cpu_clock_stepper
    import cpu_clock_stepper_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
    parameter int unsigned RUN_HALF   = DEF_RUN_HALF,
    parameter int unsigned PULSE_HALF = DEF_PULSE_HALF
) (
    input logic                 clk,
    input logic                 rst,
    cpu_clock_stepper_if.master bus
);

    localparam int unsigned DW = cnt_width(RUN_HALF);
    localparam int unsigned PW = cnt_width(PULSE_HALF);
    localparam logic [DW-1:0] DIV_LAST   = DW'(RUN_HALF - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_HALF - 1);

    logic          mode_meta;
    logic          mode_sync;
    logic          step_req;
    logic          key_db;
    db_state_t     db_state;
    gen_state_t    gen_state;
    logic [DW-1:0] div_cnt;
    logic [PW-1:0] pulse_cnt;
    logic          cpu_clk;
    logic          cpu_clk_rise;
    logic [7:0]    step_count;

    key_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_key (
        .clk     (clk),
        .rst     (rst),
        .key_n   (bus.key_n),
        .key_db  (key_db),
        .step_req(step_req),
        .db_state(db_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_meta <= 1'b0;
            mode_sync <= 1'b0;
        end else begin
            mode_meta <= bus.mode_run;
            mode_sync <= mode_meta;
        end
    end

    // GEN_RUN is the latched run mode; GEN_IDLE is the only place step mode samples the switch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_state    <= GEN_IDLE;
            div_cnt      <= '0;
            pulse_cnt    <= '0;
            cpu_clk      <= 1'b0;
            cpu_clk_rise <= 1'b0;
            step_count   <= 8'd0;
        end else begin
            cpu_clk_rise <= 1'b0;
            case (gen_state)
                GEN_IDLE: begin
                    if (mode_sync) begin
                        gen_state <= GEN_RUN;
                        div_cnt   <= '0;
                    end else if (step_req) begin
                        gen_state    <= GEN_HIGH;
                        pulse_cnt    <= '0;
                        cpu_clk      <= 1'b1;
                        cpu_clk_rise <= 1'b1;
                        step_count   <= step_count + 8'd1;
                    end
                end
                GEN_HIGH: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        gen_state <= GEN_LOW;
                        pulse_cnt <= '0;
                        cpu_clk   <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                GEN_LOW: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        gen_state <= GEN_IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                GEN_RUN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (cpu_clk) begin
                            cpu_clk <= 1'b0;
                        end else if (!mode_sync) begin
                            // Leave run only after a full low half-period.
                            gen_state <= GEN_IDLE;
                        end else begin
                            cpu_clk      <= 1'b1;
                            cpu_clk_rise <= 1'b1;
                            step_count   <= step_count + 8'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: gen_state <= GEN_IDLE;
            endcase
        end
    end

    assign bus.cpu_clk      = cpu_clk;
    assign bus.cpu_clk_rise = cpu_clk_rise;
    assign bus.step_count   = step_count;
    assign bus.key_db       = key_db;
    assign bus.db_state     = db_state;

endmodule

// File: tb/tb_cpu_clock_stepper.sv
// Directed bench for cpu_clock_stepper with DB_CYCLES=8, RUN_HALF=5, PULSE_HALF=4.
// Inputs change and outputs are sampled on the falling clk edge.
module tb_cpu_clock_stepper;
    import cpu_clock_stepper_pkg::*;

    localparam int unsigned DB = 8;
    localparam int unsigned RH = 5;
    localparam int unsigned PH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cpu_clock_stepper_if bus();

    cpu_clock_stepper #(
        .DB_CYCLES (DB),
        .RUN_HALF  (RH),
        .PULSE_HALF(PH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       key_n;
        logic       mode_run;
        int         cycles;
        logic       exp_clk;
        logic       exp_rise;
        logic [7:0] exp_count;
        logic [1:0] exp_db;
        logic       exp_kdb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packed as {cpu_clk, cpu_clk_rise, step_count[7:0], db_state[1:0], key_db}.
    task automatic check_outs(input string name, input logic c, input logic r,
                              input logic [7:0] cnt, input logic [1:0] db, input logic kdb);
        check(name, {19'd0, bus.cpu_clk, bus.cpu_clk_rise, bus.step_count, bus.db_state, bus.key_db},
              {19'd0, c, r, cnt, db, kdb});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_release();
        bus.key_n = 1'b0;
        tick(12);
        bus.key_n = 1'b1;
        tick(12);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       e_clk;
        logic       e_rise;
        logic [7:0] e_cnt;

        bus.key_n    = 1'b1;
        bus.mode_run = 1'b0;

        // Clean press: key falls, pulse rises 11 edges later, 4 high / 4 low, then release.
        vecs.push_back('{1'b1, 1'b0, 100, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0,   2, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0,   1, 1'b0, 1'b0, 8'd0, 2'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0,   7, 1'b0, 1'b0, 8'd0, 2'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0,   1, 1'b1, 1'b1, 8'd1, 2'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0,   1, 1'b1, 1'b0, 8'd1, 2'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0,   2, 1'b1, 1'b0, 8'd1, 2'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0,   1, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0,  15, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1});
        vecs.push_back('{1'b1, 1'b0,   3, 1'b0, 1'b0, 8'd1, 2'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b0,   7, 1'b0, 1'b0, 8'd1, 2'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b0,   1, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0,  20, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0});

        tick(3);
        check_outs("reset_state", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            bus.key_n    = vecs[i].key_n;
            bus.mode_run = vecs[i].mode_run;
            tick(vecs[i].cycles);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_clk, vecs[i].exp_rise,
                       vecs[i].exp_count, vecs[i].exp_db, vecs[i].exp_kdb);
        end

        // Bouncy press: 3-cycle bounces never survive debounce, then a solid hold.
        for (int s = 0; s < 7; s++) begin
            bus.key_n = (s % 2 == 0) ? 1'b0 : 1'b1;
            tick((s < 6) ? 3 : 2);
        end
        check_outs("bounce_no_pulse", 1'b0, 1'b0, 8'd1, 2'd0, 1'b0);
        tick(30);
        check_outs("bounce_one_pulse", 1'b0, 1'b0, 8'd2, 2'd2, 1'b1);
        for (int s = 0; s < 4; s++) begin
            bus.key_n = (s % 2 == 0) ? 1'b1 : 1'b0;
            tick(3);
        end
        check_outs("release_bounce", 1'b0, 1'b0, 8'd2, 2'd2, 1'b1);
        bus.key_n = 1'b1;
        tick(20);
        check_outs("release_done", 1'b0, 1'b0, 8'd2, 2'd0, 1'b0);

        // Run mode: first rise 3+5 edges after the switch, then a 10-cycle period.
        bus.mode_run = 1'b1;
        for (int k = 1; k <= 99; k++) begin
            tick(1);
            e_clk  = (k >= 8) && (((k - 8) % 10) < 5);
            e_rise = (k >= 8) && (((k - 8) % 10) == 0);
            e_cnt  = 8'(2 + ((k >= 8) ? ((k - 8) / 10 + 1) : 0));
            check($sformatf("run_k%0d", k), {22'd0, bus.cpu_clk, bus.cpu_clk_rise, bus.step_count},
                  {22'd0, e_clk, e_rise, e_cnt});
            if (k == 50) check("run_key_held", {30'd0, bus.db_state}, 32'd2);
            if (k == 30) bus.key_n = 1'b0;
            if (k == 60) bus.key_n = 1'b1;
            if (k == 99) bus.mode_run = 1'b0;
        end
        // Switch dropped mid-high at k=99: high ends at 103, low half runs out, clock stays low.
        for (int k = 100; k <= 130; k++) begin
            tick(1);
            e_clk = (k < 103);
            check($sformatf("run_stop_k%0d", k), {22'd0, bus.cpu_clk, bus.cpu_clk_rise, bus.step_count},
                  {22'd0, e_clk, 1'b0, 8'd12});
        end
        check_outs("run_exit_idle", 1'b0, 1'b0, 8'd12, 2'd0, 1'b0);

        // Asynchronous reset while cpu_clk is high, between clock edges.
        bus.key_n = 1'b0;
        tick(12);
        check_outs("pre_reset_high", 1'b1, 1'b0, 8'd13, 2'd2, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("reset_async", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        bus.key_n = 1'b1;
        tick(2);
        rst = 1'b1;

        // 256 presses wrap step_count back to zero.
        press_release();
        check_outs("wrap_first", 1'b0, 1'b0, 8'd1, 2'd0, 1'b0);
        for (int p = 2; p <= 255; p++) press_release();
        check_outs("wrap_255", 1'b0, 1'b0, 8'd255, 2'd0, 1'b0);
        press_release();
        check_outs("wrap_zero", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_clock_stepper.md
Name: cpu_clock_stepper

Overview:
- Input-side companion to the board display path: it turns board inputs into the CPU clock.
- Debounces the step key and synchronizes the run/step mode switch.
- Drives cpu_clk as either a free-running divided clock (run mode) or one full clock pulse per debounced key press (step mode).
- Sits between the DE10-Lite KEY/SW pins and the RISC_SPM clk input, replacing the bare divider. Also exports a step counter and debug state for LEDs/HEX.

Parameters:
- DB_CYCLES, 500000: consecutive stable clk cycles required to accept a key level change (10 ms at 50 MHz).
- RUN_HALF, 25000000: clk cycles per cpu_clk half-period in run mode.
- PULSE_HALF, 1000: clk cycles of cpu_clk high, then low, per step pulse.

Ports:
- clk  in  1  50 MHz board clock.
- rst  in  1  asynchronous active-low reset (KEY[0]).
- key_n  in  1  raw step key, active-low, asynchronous to clk.
- mode_run  in  1  raw switch level: 1 = run, 0 = step; asynchronous.
- cpu_clk  out  1  registered CPU clock.
- cpu_clk_rise  out  1  one-clk-cycle strobe in the cycle cpu_clk goes 0->1.
- step_count  out  8  number of cpu_clk rising edges since reset, wraps.
- key_db  out  1  debounced key, 1 = pressed.
- db_state  out  2  debounce FSM state, for LEDs.

Behaviour:
- Reset (rst=0, async):
  - cpu_clk=0, cpu_clk_rise=0, step_count=0, key_db=0, db_state=IDLE.
  - All counters 0; synchronizer flops reset to key released (1) and mode step (0).
  - Reset mid-pulse or mid-half-period forces cpu_clk low immediately.
- Synchronizers: 2-flop on key_n and mode_run. All logic uses the synchronized versions; 2-cycle input latency.
- Debounce FSM (db_state encodings 0..3):
  - IDLE: key released and stable. If sync key low, go to PRESS_DB with counter=0.
  - PRESS_DB: counter increments while key stays low. If key returns high, go back to IDLE (bounce, no request). When counter reaches DB_CYCLES-1, go to HELD.
  - HELD: key_db=1. Issue a one-cycle step_req in the transition cycle into HELD (exactly one per press). If sync key high, go to REL_DB with counter=0.
  - REL_DB: counter increments while key stays high. If key goes low, return to HELD without a new step_req. When counter reaches DB_CYCLES-1, go to IDLE and set key_db=0.
- Clock generator, mode latched as cur_mode:
  - cur_mode updates from the sync switch only when cpu_clk=0 and no step pulse is in progress, so the clock never glitches.
  - Run: divider counts 0..RUN_HALF-1 and toggles cpu_clk at terminal count. The divider is cleared on entry to run mode, so the first rise occurs RUN_HALF cycles after the mode takes effect.
  - Run -> step request while cpu_clk high: complete the current high half-period and the following low half-period, then stop low.
  - Step: step_req while idle starts a pulse. cpu_clk=1 for PULSE_HALF cycles, then 0 for PULSE_HALF cycles, then idle.
  - step_req during a pulse in progress, or in run mode, is dropped (not queued).
- cpu_clk_rise is registered, asserted in the same cycle cpu_clk becomes 1. step_count increments on that cycle in either mode; 255 -> 0 wrap.
- Widths: counters are sized by clog2 of their parameter. Parameters must satisfy DB_CYCLES >= 1, RUN_HALF >= 2, PULSE_HALF >= 1.

Decomposition:
- Shared package:
  - db_state_t encoding (IDLE=0, PRESS_DB=1, HELD=2, REL_DB=3).
  - Clock generator state encoding (GEN_IDLE, GEN_HIGH, GEN_LOW, GEN_RUN).
  - Default-parameter constants for 50 MHz.
- Sub-module key_debounce: synchronizer plus debounce FSM, outputs key_db, step_req and db_state. Instantiated once; reusable for KEY[1] and other keys.

Test Plan (DB_CYCLES=8, RUN_HALF=5, PULSE_HALF=4):
- Reset then idle: hold rst low 3 cycles, release, mode_run=0, key released for 100 cycles -> cpu_clk stays 0, step_count=0, db_state=0.
- Clean press: key_n low for 30 cycles, then high -> exactly one cpu_clk pulse (4 high, 4 low). Rise occurs 2+8 cycles after key_n falls, ±1. step_count=1; db_state walks 0,1,2,3,0.
- Bouncy press: key_n toggles every 3 cycles for 20 cycles, then holds low 30 cycles -> one pulse only, step_count=1. Release bounces give no second pulse.
- Run mode: mode_run=1 for 100 cycles -> cpu_clk period 10 cycles, 50% duty, cpu_clk_rise strobes 10 cycles apart. step_count increments per rise; key presses have no effect.
- Run -> step mid-high: set mode_run=0 while cpu_clk=1 -> high phase completes (5 cycles), one low half-period, then cpu_clk held 0 with no truncated pulse.
- Reset mid-pulse and wrap: assert rst during cpu_clk high -> cpu_clk=0 asynchronously, all outputs cleared. Separately, 256 presses -> step_count wraps to 0.
